// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the instruction fetch path.
//  XLEN            architectural register / address width
//  fetch_state_t   fetch sequencer FSM states
//  redirect_t      redirect-priority encoding, also used by the trap/CSR block
package fetch_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_HOLD
  } fetch_state_t;

  // Ordered by priority: a trap beats a branch; a misaligned branch target
  // is converted into a trap to TRAP_VECTOR.
  typedef enum logic [1:0] {
    RD_NONE,
    RD_TRAP,
    RD_BRANCH,
    RD_MISALIGNED
  } redirect_t;

endpackage

// File: rtl/fetch_sequencer_next_pc_select.sv
// next_pc_select: combinational priority mux for the fetch PC.
//  pc             in   current fetch PC
//  trap           in   trap request
//  branch_taken   in   branch redirect request
//  branch_target  in   branch redirect target
//  kind           out  which redirect (if any) wins this cycle
//  redirect_pc    out  target PC when kind != RD_NONE
//  seq_pc         out  sequential PC (pc + 4, wraps modulo 2^32)
//  misaligned     out  branch target not word aligned and no trap present
module next_pc_select
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic [XLEN-1:0] pc,
  input  logic            trap,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output redirect_t       kind,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] seq_pc,
  output logic            misaligned
);

  always_comb begin
    kind        = RD_NONE;
    redirect_pc = TRAP_VECTOR;
    if (trap) begin
      kind = RD_TRAP;
    end else if (branch_taken) begin
      if (branch_target[1:0] == 2'b00) begin
        kind        = RD_BRANCH;
        redirect_pc = branch_target;
      end else begin
        // Misaligned target: fall back to the trap vector.
        kind = RD_MISALIGNED;
      end
    end
  end

  assign seq_pc     = pc + XLEN'(4);
  assign misaligned = (kind == RD_MISALIGNED);

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the architectural PC and sequences instruction fetch.
//  One request outstanding at a time, a single-entry instruction buffer for
//  decode, and redirects with priority trap > branch > sequential PC+4.
// Ports:
//  i_Clock, i_Reset (async, active high)
//  o_ImemReq/o_ImemAddr      fetch request and word-aligned address
//  i_ImemAck/i_ImemData      request accepted; data valid in the same cycle
//  o_InstrValid/o_Instruction/o_InstrPc  buffered instruction to decode
//  i_DecodeReady             decode consumes the buffer when valid & ready
//  i_BranchTaken/i_BranchTarget, i_Trap  redirect requests (1-cycle pulses)
//  o_MisalignedTrap          1-cycle pulse after a misaligned branch redirect
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic            i_Clock,
  input  logic            i_Reset,
  output logic            o_ImemReq,
  output logic [XLEN-1:0] o_ImemAddr,
  input  logic            i_ImemAck,
  input  logic [XLEN-1:0] i_ImemData,
  output logic            o_InstrValid,
  output logic [XLEN-1:0] o_Instruction,
  output logic [XLEN-1:0] o_InstrPc,
  input  logic            i_DecodeReady,
  input  logic            i_BranchTaken,
  input  logic [XLEN-1:0] i_BranchTarget,
  input  logic            i_Trap,
  output logic            o_MisalignedTrap
);

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] pending_reg, pending_next;
  logic            squash_reg, squash_next;
  logic [XLEN-1:0] instr_reg, instr_pc_reg;
  logic            misaligned_reg, misaligned_next;
  logic            capture;

  redirect_t       kind;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] seq_pc;
  logic            misaligned;
  logic            redirect;

  next_pc_select #(
    .TRAP_VECTOR(TRAP_VECTOR)
  ) u_next_pc_select (
    .pc           (pc_reg),
    .trap         (i_Trap),
    .branch_taken (i_BranchTaken),
    .branch_target(i_BranchTarget),
    .kind         (kind),
    .redirect_pc  (redirect_pc),
    .seq_pc       (seq_pc),
    .misaligned   (misaligned)
  );

  assign redirect = (kind != RD_NONE);

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    pending_next    = pending_reg;
    squash_next     = squash_reg;
    misaligned_next = 1'b0;
    capture         = 1'b0;
    case (state_reg)
      S_BOOT: begin
        state_next = S_REQ;
      end
      S_REQ: begin
        misaligned_next = misaligned;
        if (i_ImemAck) begin
          if (!squash_reg && !redirect) begin
            capture    = 1'b1;
            pc_next    = seq_pc;
            state_next = S_HOLD;
          end else begin
            // Returned word belongs to a stale path; a redirect arriving with
            // the ack is newer than any pending target.
            pc_next     = redirect ? redirect_pc : pending_reg;
            squash_next = 1'b0;
          end
        end else if (redirect) begin
          // Request cannot be cancelled: keep the address on the bus and
          // remember where to go once it completes.
          pending_next = redirect_pc;
          squash_next  = 1'b1;
        end
      end
      S_HOLD: begin
        misaligned_next = misaligned;
        if (redirect) begin
          pc_next    = redirect_pc;
          state_next = S_REQ;
        end else if (i_DecodeReady) begin
          state_next = S_REQ;
        end
      end
      default: begin
        state_next = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_reg      <= S_BOOT;
      pc_reg         <= RESET_VECTOR;
      pending_reg    <= RESET_VECTOR;
      squash_reg     <= 1'b0;
      instr_reg      <= '0;
      instr_pc_reg   <= '0;
      misaligned_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      pending_reg    <= pending_next;
      squash_reg     <= squash_next;
      misaligned_reg <= misaligned_next;
      if (capture) begin
        instr_reg    <= i_ImemData;
        instr_pc_reg <= pc_reg;
      end
    end
  end

  assign o_ImemReq        = (state_reg == S_REQ);
  assign o_ImemAddr       = pc_reg;
  assign o_InstrValid     = (state_reg == S_HOLD);
  assign o_Instruction    = instr_reg;
  assign o_InstrPc        = instr_pc_reg;
  assign o_MisalignedTrap = misaligned_reg;

endmodule
